// File: rtl/mips_bus_arbiter_if.sv
// Avalon-MM bus bundle for the arbiter: one instance per CPU master port and
// one for the shared memory slave port.
interface mips_bus_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter (M0 fetch, M1 load/store) with zero added latency,
// ownership lock across wait states and bounded fetch starvation.
// Optional transfer/stall counters are enabled with ARB_PERF_COUNT_EN.
module mips_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mips_bus_arbiter_if.slave   m0,
    mips_bus_arbiter_if.slave   m1,
    mips_bus_arbiter_if.master  s,
`ifdef ARB_PERF_COUNT_EN
    output logic [31:0]         perf_m0_grants,
    output logic [31:0]         perf_m1_grants,
    output logic [31:0]         perf_m0_stall,
`endif
    output logic [1:0]          grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_M0,
        LOCK_M1
    } owner_t;

    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             m0_req, m1_req;
    logic             gnt0, gnt1;
    logic             m0_done, m1_done;

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

    always_comb begin
        owner_d = owner_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (owner_q)
            IDLE: begin
                // M1 wins ties unless fetch has been starved for STARVE_LIMIT transfers
                if (m0_req && (!m1_req || starve_cnt_q == LIMIT)) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 && s.waitrequest) begin
                    owner_d = LOCK_M0;
                end else if (gnt1 && s.waitrequest) begin
                    owner_d = LOCK_M1;
                end
            end
            LOCK_M0: begin
                if (!m0_req) begin
                    owner_d = IDLE;
                end else begin
                    gnt0 = 1'b1;
                    if (!s.waitrequest) owner_d = IDLE;
                end
            end
            LOCK_M1: begin
                if (!m1_req) begin
                    owner_d = IDLE;
                end else begin
                    gnt1 = 1'b1;
                    if (!s.waitrequest) owner_d = IDLE;
                end
            end
            default: owner_d = IDLE;
        endcase
        // The state flops reset asynchronously, but the IDLE pick is combinational
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_done = gnt0 & ~s.waitrequest;
    assign m1_done = gnt1 & ~s.waitrequest;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m0_req || m0_done) begin
            starve_cnt_d = '0;
        end else if (m1_done && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        s.address    = 32'h0;
        s.read       = 1'b0;
        s.write      = 1'b0;
        s.writedata  = 32'h0;
        s.byteenable = 4'h0;
        if (gnt0) begin
            s.address    = m0.address;
            s.read       = m0.read;
            s.write      = m0.write;
            s.writedata  = m0.writedata;
            s.byteenable = m0.byteenable;
        end else if (gnt1) begin
            s.address    = m1.address;
            s.read       = m1.read;
            s.write      = m1.write;
            s.writedata  = m1.writedata;
            s.byteenable = m1.byteenable;
        end
    end

    assign m0.waitrequest = gnt0 ? s.waitrequest : 1'b1;
    assign m1.waitrequest = gnt1 ? s.waitrequest : 1'b1;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
    assign grant          = {gnt1, gnt0};

`ifdef ARB_PERF_COUNT_EN
    logic [31:0] perf_m0_grants_q, perf_m0_grants_d;
    logic [31:0] perf_m1_grants_q, perf_m1_grants_d;
    logic [31:0] perf_m0_stall_q,  perf_m0_stall_d;

    // Counters wrap naturally at 32 bits
    always_comb begin
        perf_m0_grants_d = perf_m0_grants_q + {31'h0, m0_done};
        perf_m1_grants_d = perf_m1_grants_q + {31'h0, m1_done};
        perf_m0_stall_d  = perf_m0_stall_q + {31'h0, (m0_req & ~gnt0)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_m0_grants_q <= 32'h0;
            perf_m1_grants_q <= 32'h0;
            perf_m0_stall_q  <= 32'h0;
        end else begin
            perf_m0_grants_q <= perf_m0_grants_d;
            perf_m1_grants_q <= perf_m1_grants_d;
            perf_m0_stall_q  <= perf_m0_stall_d;
        end
    end

    assign perf_m0_grants = perf_m0_grants_q;
    assign perf_m1_grants = perf_m1_grants_q;
    assign perf_m0_stall  = perf_m0_stall_q;
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: directed vectors push expected bus
// responses into a queue, a negedge monitor pops and compares them.
module tb_mips_bus_arbiter;

    localparam logic [31:0] A0 = 32'hBFC0_0000;
    localparam logic [31:0] A1 = 32'h1000_0040;
    localparam logic [31:0] W0 = 32'h0BAD_F00D;
    localparam logic [31:0] W1 = 32'hCAFE_1234;

    logic       clk;
    logic       reset;
    logic [1:0] grant;
`ifdef ARB_PERF_COUNT_EN
    logic [31:0] perf_m0_grants, perf_m1_grants, perf_m0_stall;
`endif

    mips_bus_arbiter_if m0_if ();
    mips_bus_arbiter_if m1_if ();
    mips_bus_arbiter_if s_if ();

    mips_bus_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .s              (s_if),
`ifdef ARB_PERF_COUNT_EN
        .perf_m0_grants (perf_m0_grants),
        .perf_m1_grants (perf_m1_grants),
        .perf_m0_stall  (perf_m0_stall),
`endif
        .grant          (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  grant;
        logic        sread;
        logic        swrite;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [3:0]  sbe;
        logic        m0w;
        logic        m1w;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, vec_n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grant",          {30'h0, grant},                e.grant);
            chk("s_read",         {31'h0, s_if.read},            {31'h0, e.sread});
            chk("s_write",        {31'h0, s_if.write},           {31'h0, e.swrite});
            chk("s_address",      s_if.address,                  e.saddr);
            chk("s_writedata",    s_if.writedata,                e.swdata);
            chk("s_byteenable",   {28'h0, s_if.byteenable},      {28'h0, e.sbe});
            chk("m0_waitrequest", {31'h0, m0_if.waitrequest},    {31'h0, e.m0w});
            chk("m1_waitrequest", {31'h0, m1_if.waitrequest},    {31'h0, e.m1w});
            chk("m0_readdata",    m0_if.readdata,                e.rdata);
            chk("m1_readdata",    m1_if.readdata,                e.rdata);
        end
    end

    // Apply one cycle of stimulus with hand-computed grant and waitrequests.
    task automatic step(input logic rst, input logic m0r, input logic m0wr,
                        input logic m1r, input logic m1wr, input logic swait,
                        input logic [1:0] eg, input logic em0w, input logic em1w);
        exp_t e;
        reset             = rst;
        m0_if.read        = m0r;
        m0_if.write       = m0wr;
        m1_if.read        = m1r;
        m1_if.write       = m1wr;
        s_if.waitrequest  = swait;
        s_if.readdata     = 32'hD000_0000 + 32'(vec_n);
        e.grant  = eg;
        e.sread  = (eg == 2'b01) ? m0r  : (eg == 2'b10) ? m1r  : 1'b0;
        e.swrite = (eg == 2'b01) ? m0wr : (eg == 2'b10) ? m1wr : 1'b0;
        e.saddr  = (eg == 2'b01) ? A0   : (eg == 2'b10) ? A1   : 32'h0;
        e.swdata = (eg == 2'b01) ? W0   : (eg == 2'b10) ? W1   : 32'h0;
        e.sbe    = (eg == 2'b01) ? 4'hF : (eg == 2'b10) ? 4'h3 : 4'h0;
        e.m0w    = em0w;
        e.m1w    = em1w;
        e.rdata  = s_if.readdata;
        q.push_back(e);
        @(posedge clk);
        #1;
        vec_n++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout queue=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b0;
        m0_if.address    = A0;
        m0_if.writedata  = W0;
        m0_if.byteenable = 4'hF;
        m0_if.read       = 1'b0;
        m0_if.write      = 1'b0;
        m1_if.address    = A1;
        m1_if.writedata  = W1;
        m1_if.byteenable = 4'h3;
        m1_if.read       = 1'b0;
        m1_if.write      = 1'b0;
        s_if.waitrequest = 1'b0;
        s_if.readdata    = 32'h0;
        @(posedge clk);
        #1;

        // Held in reset with both masters requesting and a noisy slave
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b1);

        // Lone fetch, zero-wait slave: granted in the same cycle
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

        // Both request, M1 wins and is held through three wait states
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

        // Reset to clear starvation and counters, then continuous contention
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
        end
`ifdef ARB_PERF_COUNT_EN
        chk("perf_m0_grants", perf_m0_grants, 32'd2);
        chk("perf_m1_grants", perf_m1_grants, 32'd4);
        chk("perf_m0_stall",  perf_m0_stall,  32'd4);
`endif

        // Reset in the middle of a locked M1 write, then fresh arbitration
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

        // Lock on M0 ignores M1; M0 dropping its request releases the lock
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);

        // Simultaneous read and write from M1 pass through untouched
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
